// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared constants and types for the RPSC input conditioner.
// Holds the channel map, default channel count and the debounce state enum.
package rpsc_pkg;

   localparam int RPSC_N_INPUTS = 8;

   localparam int CH_FAN_PERM   = 0;
   localparam int CH_CA_PERM    = 1;
   localparam int CH_G1_PERM    = 2;
   localparam int CH_ANODE_PERM = 3;
   localparam int CH_FAN_ON     = 4;
   localparam int CH_CA_ON      = 5;
   localparam int CH_G1_ON      = 6;
   localparam int CH_ANODE_ON   = 7;

   typedef enum logic {
      STABLE = 1'b0,
      QUAL   = 1'b1
   } filt_state_t;

endpackage

// File: rtl/rpsc_debounce_ch.sv
// rpsc_debounce_ch: one input channel - 2-flop sync, debounce FSM,
// bounce counter and sticky chatter flag.
// Ports: clk, reset (async high), i_raw, i_wrap (window wrap strobe),
//   i_clr (chatter clear), o_filt, o_pulse, o_chatter.
// Chatter logic built only when RPSC_CHATTER_DET_EN is defined.
module rpsc_debounce_ch
   import rpsc_pkg::*;
#(
   parameter int   FILT_CYCLES = 1000,
   parameter logic INIT_VAL    = 1'b0,
   parameter int   CHATTER_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   input  logic i_wrap,
   input  logic i_clr,
   output logic o_filt,
   output logic o_pulse,
   output logic o_chatter
);

   localparam int CNT_W =
      (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(FILT_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_filt;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;
   filt_state_t      r_state;

   logic [CNT_W-1:0] w_cnt_nxt;
   filt_state_t      w_state_nxt;
   logic             w_diff;
   logic             w_toggle;
   logic             w_bounce;

   assign w_diff = r_s2 ^ r_filt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_toggle    = 1'b0;
      w_bounce    = 1'b0;
      unique case (r_state)
         STABLE: begin
            if (w_diff) begin
               w_state_nxt = QUAL;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         QUAL: begin
            if (!w_diff) begin
               // level fell back before qualifying: a bounce
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
               w_bounce    = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
               w_toggle    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1    <= INIT_VAL;
         r_s2    <= INIT_VAL;
         r_filt  <= INIT_VAL;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_state <= STABLE;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_pulse <= w_toggle;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
         if (w_toggle) begin
            r_filt <= ~r_filt;
         end
      end
   end

   assign o_filt  = r_filt;
   assign o_pulse = r_pulse;

`ifdef RPSC_CHATTER_DET_EN
   localparam int BNC_W = $clog2(CHATTER_MAX + 1);
   localparam logic [BNC_W-1:0] BNC_MAX =
      BNC_W'(CHATTER_MAX);

   logic [BNC_W-1:0] r_bcnt;
   logic             r_chat;
   logic             w_reach;

   // a bounce on the wrap edge is dropped
   assign w_reach = w_bounce && !i_wrap &&
                    (r_bcnt == BNC_MAX - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bcnt <= '0;
      end else if (i_wrap) begin
         r_bcnt <= '0;
      end else if (w_bounce && r_bcnt != BNC_MAX) begin
         r_bcnt <= r_bcnt + 1'b1;
      end
   end

   // set has priority over clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chat <= 1'b0;
      end else if (w_reach) begin
         r_chat <= 1'b1;
      end else if (i_clr) begin
         r_chat <= 1'b0;
      end
   end

   assign o_chatter = r_chat;
`else
   logic w_unused;
   assign w_unused  = ^{i_wrap, i_clr, w_bounce,
                        CHATTER_MAX[0]};
   assign o_chatter = 1'b0;
`endif

endmodule

// File: rtl/rpsc_input_filter.sv
// rpsc_input_filter: N_CH synchronised, debounced RPSC inputs with
// change strobes and chatter flags; owns the shared chatter window.
// Ports: clk, reset (async high), raw_in, clr_chatter,
//   filt_out, change_pulse, chatter_flag.
// Macro RPSC_CHATTER_DET_EN builds the chatter window/counters.
module rpsc_input_filter
   import rpsc_pkg::*;
#(
   parameter int              N_CH        = RPSC_N_INPUTS,
   parameter int              FILT_CYCLES = 1000,
   parameter logic [N_CH-1:0] INIT_VAL    = '0,
   parameter int              CHATTER_WIN = 100000,
   parameter int              CHATTER_MAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   input  logic            clr_chatter,
   output logic [N_CH-1:0] filt_out,
   output logic [N_CH-1:0] change_pulse,
   output logic [N_CH-1:0] chatter_flag
);

   logic w_wrap;

`ifdef RPSC_CHATTER_DET_EN
   localparam int WIN_W =
      (CHATTER_WIN > 1) ? $clog2(CHATTER_WIN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST =
      WIN_W'(CHATTER_WIN - 1);

   logic [WIN_W-1:0] r_win;

   assign w_wrap = (r_win == WIN_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win <= '0;
      end else if (w_wrap) begin
         r_win <= '0;
      end else begin
         r_win <= r_win + 1'b1;
      end
   end
`else
   logic w_unused;
   assign w_unused = CHATTER_WIN[0];
   assign w_wrap   = 1'b0;
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      rpsc_debounce_ch #(
         .FILT_CYCLES (FILT_CYCLES),
         .INIT_VAL    (INIT_VAL[g]),
         .CHATTER_MAX (CHATTER_MAX)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_raw     (raw_in[g]),
         .i_wrap    (w_wrap),
         .i_clr     (clr_chatter),
         .o_filt    (filt_out[g]),
         .o_pulse   (change_pulse[g]),
         .o_chatter (chatter_flag[g])
      );
   end

endmodule

// File: tb/tb_rpsc_input_filter.sv
// tb_rpsc_input_filter: directed + random checks of rpsc_input_filter
// against a run-length behavioural model of the debounce/chatter rules.
module tb_rpsc_input_filter;

   localparam int         N    = 8;
   localparam int         FILT = 4;
   localparam int         WIN  = 50;
   localparam int         CMAX = 3;
   localparam logic [7:0] INIT = 8'h0F;
`ifdef RPSC_CHATTER_DET_EN
   localparam logic [7:0] CHAT_EN = 8'h01;
`else
   localparam logic [7:0] CHAT_EN = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] raw_in = INIT;
   logic       clr_chatter = 1'b0;
   logic [7:0] filt_out;
   logic [7:0] change_pulse;
   logic [7:0] chatter_flag;

   int n_tests = 0;
   int n_fail  = 0;

   rpsc_input_filter #(
      .N_CH        (N),
      .FILT_CYCLES (FILT),
      .INIT_VAL    (INIT),
      .CHATTER_WIN (WIN),
      .CHATTER_MAX (CMAX)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (raw_in),
      .clr_chatter  (clr_chatter),
      .filt_out     (filt_out),
      .change_pulse (change_pulse),
      .chatter_flag (chatter_flag)
   );

   always #5 clk = ~clk;

   // reference model
   logic [7:0] m_hist[$];
   logic [7:0] m_filt;
   logic [7:0] m_pulse;
   logic [7:0] m_flag;
   int         m_run[N];
   int         m_bcnt[N];
   int         m_edge;

   task automatic model_reset();
      m_hist = '{INIT, INIT};
      m_filt  = INIT;
      m_pulse = '0;
      m_flag  = '0;
      m_edge  = 0;
      for (int c = 0; c < N; c++) begin
         m_run[c]  = 0;
         m_bcnt[c] = 0;
      end
   endtask

   task automatic model_edge(input logic [7:0] r,
                             input logic c);
      logic [7:0] s2;
      bit wrap, bounce, reach;
      s2 = m_hist[0];
      m_edge++;
      wrap = (m_edge % WIN) == 0;
      m_pulse = '0;
      for (int ch = 0; ch < N; ch++) begin
         bounce = 0;
         reach  = 0;
         if (s2[ch] != m_filt[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == FILT) begin
               m_filt[ch]  = ~m_filt[ch];
               m_pulse[ch] = 1'b1;
               m_run[ch]   = 0;
            end
         end else begin
            bounce    = m_run[ch] > 0;
            m_run[ch] = 0;
         end
         if (wrap) begin
            m_bcnt[ch] = 0;
         end else if (bounce && m_bcnt[ch] < CMAX) begin
            m_bcnt[ch]++;
            reach = m_bcnt[ch] == CMAX;
         end
         if (reach) m_flag[ch] = 1'b1;
         else if (c) m_flag[ch] = 1'b0;
      end
      void'(m_hist.pop_front());
      m_hist.push_back(r);
   endtask

   function automatic logic [7:0] exp_flag();
      return (CHAT_EN != 0) ? m_flag : 8'h00;
   endfunction

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_filt"}, filt_out, m_filt);
      chk({tag, "_pulse"}, change_pulse, m_pulse);
      chk({tag, "_chat"}, chatter_flag, exp_flag());
   endtask

   task automatic tick();
      logic [7:0] r;
      logic       c;
      r = raw_in;
      c = clr_chatter;
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(r, c);
      #1;
      chk_all("tick");
   endtask

   task automatic do_reset();
      raw_in      = INIT;
      clr_chatter = 1'b0;
      reset       = 1'b1;
      model_reset();
      #1;
      chk_all("rst_async");
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic glitch(input int ch, input int len,
                         input bit clr_on_abort);
      logic [7:0] v;
      v = INIT;
      raw_in[ch] = ~v[ch];
      repeat (len) tick();
      raw_in[ch] = v[ch];
      for (int i = 1; i <= 6; i++) begin
         clr_chatter = clr_on_abort && (i == 3);
         tick();
      end
      clr_chatter = 1'b0;
   endtask

   initial begin
      // 1: async reset, checked before the first clock edge
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      chk("t1_filt", filt_out, 8'h0F);
      chk("t1_pulse", change_pulse, 8'h00);
      chk("t1_chat", chatter_flag, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 2: clean rising edge on a low-init channel
      do_reset();
      raw_in[4] = 1'b1;
      repeat (5) tick();
      chk("t2_pre", {7'd0, filt_out[4]}, 8'h00);
      tick();
      chk("t2_edge6", {7'd0, filt_out[4]}, 8'h01);
      chk("t2_pulse", {7'd0, change_pulse[4]}, 8'h01);
      tick();
      chk("t2_pulse_end", {7'd0, change_pulse[4]}, 8'h00);
      raw_in[0] = 1'b0;
      repeat (6) tick();
      chk("t2_fall", {7'd0, filt_out[0]}, 8'h00);

      // 3: 3-cycle glitch rejected
      do_reset();
      glitch(6, 3, 0);
      chk("t3_filt", filt_out, INIT);
      chk("t3_chat", chatter_flag, 8'h00);

      // 4: chatter set, clear, same-edge set/clear
      do_reset();
      repeat (3) glitch(5, 2, 0);
      chk("t4_set", {7'd0, chatter_flag[5]}, CHAT_EN);
      clr_chatter = 1'b1;
      tick();
      clr_chatter = 1'b0;
      chk("t4_clr", {7'd0, chatter_flag[5]}, 8'h00);
      repeat (WIN - (m_edge % WIN)) tick();
      repeat (2) glitch(5, 2, 0);
      glitch(5, 2, 1);
      chk("t4_setwins", {7'd0, chatter_flag[5]}, CHAT_EN);

      // 5: window wrap clears the bounce count
      do_reset();
      repeat (2) glitch(5, 2, 0);
      repeat (WIN - (m_edge % WIN)) tick();
      glitch(5, 2, 0);
      chk("t5_noflag", {7'd0, chatter_flag[5]}, 8'h00);

      // 6: reset mid-qualification
      do_reset();
      raw_in[4] = 1'b1;
      repeat (5) tick();
      reset = 1'b1;
      model_reset();
      #1;
      chk("t6_async", filt_out, INIT);
      tick();
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("t6_pre", {7'd0, filt_out[4]}, 8'h00);
      tick();
      chk("t6_edge", {7'd0, filt_out[4]}, 8'h01);

      // all channels together
      do_reset();
      raw_in = ~INIT;
      repeat (6) tick();
      chk("all_pulse", change_pulse, 8'hFF);
      chk("all_filt", filt_out, ~INIT);

      // random activity
      do_reset();
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 5) == 0) raw_in[c] = ~raw_in[c];
         end
         clr_chatter = ($urandom_range(0, 29) == 0);
         tick();
      end
      clr_chatter = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
